// File: rtl/pixel_spi_out.sv
// pixel_spi_out
//   Output stage of the Mandelbrot pixel pipeline. It buffers 24-bit RGB
//   pixels in a small FIFO and sends each one MSB-first as a single
//   chip-select framed transfer on an SPI-style link.
//
//   Optional feature: define PIXEL_TAG_EN to store is_mandelbrot_in with each
//   pixel and send it as an extra leading bit, giving 25-bit frames.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   CLK_DIV  clk cycles per SPI clock half-period (>= 1)
// Ports
//   clk               sole clock, rising edge
//   rst               synchronous active-high reset
//   valid_in          one-cycle pixel strobe
//   color_in[23:0]    RGB pixel, [23:16] = R
//   is_mandelbrot_in  in-set flag (used only with PIXEL_TAG_EN)
//   ready_out         FIFO not full (combinational)
//   spi_clk_out       serial clock, idle low
//   spi_data_out      serial data, stable around spi_clk_out rising
//   spi_cs_n          frame select, active low
//   busy              FSM active or FIFO non-empty
//   overflow          sticky: a pixel was dropped
module pixel_spi_out #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [23:0] color_in,
  input  logic        is_mandelbrot_in,
  output logic        ready_out,
  output logic        spi_clk_out,
  output logic        spi_data_out,
  output logic        spi_cs_n,
  output logic        busy,
  output logic        overflow
);

`ifdef PIXEL_TAG_EN
  localparam int unsigned N = 25;
`else
  localparam int unsigned N = 24;
`endif

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [N-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             phase_q, phase_d;   // 1 = sclk high half of a bit
  logic [N-1:0]     shreg_q, shreg_d;

  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic data_q, data_d;
  logic busy_q, busy_d;
  logic overflow_q, overflow_d;

  logic         full, push, pop, div_last;
  logic [N-1:0] entry;

`ifdef PIXEL_TAG_EN
  assign entry = {is_mandelbrot_in, color_in};
`else
  logic unused_tag;
  assign unused_tag = is_mandelbrot_in;
  assign entry      = color_in;
`endif

  assign full      = (count_q == CNT_FULL);
  // A push is judged against the count before this cycle's pop.
  assign push      = valid_in && !full;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign div_last  = (div_q == DIV_LAST);
  assign ready_out = !rst && !full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (valid_in && full);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q];
          div_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (phase_q) begin
            // high->low: present the next bit for the low half
            phase_d = 1'b0;
            shreg_d = {shreg_q[N-2:0], 1'b0};
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            phase_d = 1'b1;
            bit_d   = bit_q + BIT_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin  // ST_HOLD
        if (div_last) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
    endcase
  end

  // Pins are registered from the current state, so they trail the FSM by
  // one cycle; cs_n therefore falls two edges after the pushing edge.
  always_comb begin
    cs_n_d = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
    sclk_d = (state_q == ST_SHIFT) && phase_q;
    data_d = cs_n_d ? 1'b0 : shreg_q[N-1];
    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      shreg_q    <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  assign spi_cs_n     = cs_n_q;
  assign spi_clk_out  = sclk_q;
  assign spi_data_out = data_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pixel_spi_out.sv
// tb_pixel_spi_out
//   Directed bench for pixel_spi_out. dut0 uses CLK_DIV=2, dut1 uses
//   CLK_DIV=1; both DEPTH=4. Frames are reassembled from the serial pins and
//   compared against the pixels that were pushed.
module tb_pixel_spi_out;

`ifdef PIXEL_TAG_EN
  localparam int NB = 25;
`else
  localparam int NB = 24;
`endif
  localparam int LOW0 = 2 * (2 * NB + 1);
  localparam int PER0 = 1 + 2 + 2 * NB * 2 + 2;
  localparam int PER1 = 1 + 1 + 2 * NB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic v0, v1, t0, t1;
  logic [23:0] c0, c1;
  logic r0, sc0, sd0, cs0, b0, o0;
  logic r1, sc1, sd1, cs1, b1, o1;

  pixel_spi_out #(.DEPTH(4), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .valid_in(v0), .color_in(c0), .is_mandelbrot_in(t0),
    .ready_out(r0), .spi_clk_out(sc0), .spi_data_out(sd0), .spi_cs_n(cs0),
    .busy(b0), .overflow(o0)
  );

  pixel_spi_out #(.DEPTH(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(v1), .color_in(c1), .is_mandelbrot_in(t1),
    .ready_out(r1), .spi_clk_out(sc1), .spi_data_out(sd1), .spi_cs_n(cs1),
    .busy(b1), .overflow(o1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] fr(input logic tag, input logic [23:0] c);
`ifdef PIXEL_TAG_EN
    return {7'd0, tag, c};
`else
    return {8'd0, c};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame capture: shift data on each sclk rise, keep only complete frames.
  logic [31:0] sh0 = '0, sh1 = '0;
  int nb0 = 0, nb1 = 0;
  logic ps0 = 1'b0, pc0 = 1'b1, ps1 = 1'b0, pc1 = 1'b1;
  logic [31:0] q0[$], q1[$];

  always @(negedge clk) begin
    ps0 <= sc0;
    pc0 <= cs0;
    if (rst) begin
      nb0 <= 0;
      sh0 <= '0;
    end else if (cs0 && !pc0) begin
      if (nb0 == NB) q0.push_back(sh0);
      nb0 <= 0;
      sh0 <= '0;
    end else if (!cs0 && sc0 && !ps0) begin
      sh0 <= {sh0[30:0], sd0};
      nb0 <= nb0 + 1;
    end
  end

  always @(negedge clk) begin
    ps1 <= sc1;
    pc1 <= cs1;
    if (rst) begin
      nb1 <= 0;
      sh1 <= '0;
    end else if (cs1 && !pc1) begin
      if (nb1 == NB) q1.push_back(sh1);
      nb1 <= 0;
      sh1 <= '0;
    end else if (!cs1 && sc1 && !ps1) begin
      sh1 <= {sh1[30:0], sd1};
      nb1 <= nb1 + 1;
    end
  end

  function automatic logic [31:0] pop0();
    if (q0.size() == 0) return 32'hDEAD_BEEF;
    return q0.pop_front();
  endfunction

  function automatic logic [31:0] pop1();
    if (q1.size() == 0) return 32'hDEAD_BEEF;
    return q1.pop_front();
  endfunction

  task automatic wait_idle(input int which, input int lim);
    int n;
    n = 0;
    while (((which == 0) ? b0 : b1) !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < lim), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  logic [23:0] px [6];
  logic        tg [6];

  initial begin
    int t, tf, tr, tb, tr1, tf2, stage, nrise, lowseen, qs;

    px[0] = 24'h123456; tg[0] = 1'b0;
    px[1] = 24'hFFFFFF; tg[1] = 1'b1;
    px[2] = 24'h000000; tg[2] = 1'b1;
    px[3] = 24'h800001; tg[3] = 1'b0;
    px[4] = 24'h5A5A5A; tg[4] = 1'b1;
    px[5] = 24'h0F0F0F; tg[5] = 1'b0;

    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; t0 = 1'b0; t1 = 1'b0; c0 = '0; c1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",    32'(r0),  32'd0);
    chk("rst_cs_n",     32'(cs0), 32'd1);
    chk("rst_sclk",     32'(sc0), 32'd0);
    chk("rst_data",     32'(sd0), 32'd0);
    chk("rst_busy",     32'(b0),  32'd0);
    chk("rst_overflow", 32'(o0),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(r0), 32'd1);

    // Single pixel: latency, cs_n low time, busy duration, bit order
    c0 = 24'hA5C3F0; t0 = 1'b0; v0 = 1'b1;
    t = 0; tf = -1; tr = -1; tb = -1;
    while (tb < 0 && t < 400) begin
      @(negedge clk);
      v0 = 1'b0;
      t++;
      if (tf < 0 && cs0 == 1'b0) tf = t;
      if (tf >= 0 && tr < 0 && cs0 == 1'b1) tr = t;
      if (tr >= 0 && tb < 0 && b0 == 1'b0) tb = t;
    end
    chk("cs_fall_latency", 32'(tf),      32'd3);
    chk("cs_low_cycles",   32'(tr - tf), 32'(LOW0));
    chk("busy_cycles",     32'(tb),      32'(PER0 + 1));
    repeat (4) @(negedge clk);
    chk("frame_single_cnt", 32'(q0.size()), 32'd1);
    chk("frame_single",     pop0(),         fr(1'b0, 24'hA5C3F0));

    // Six consecutive pushes: five accepted, sixth dropped
    for (int i = 0; i < 6; i++) begin
      c0 = px[i]; t0 = tg[i]; v0 = 1'b1;
      if (i == 4) chk("ready_5th", 32'(r0), 32'd1);
      if (i == 5) begin
        chk("ready_6th",    32'(r0), 32'd0);
        chk("ovf_before_6", 32'(o0), 32'd0);
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    chk("ovf_after_6", 32'(o0), 32'd1);
    wait_idle(0, 1000);
    chk("burst_frame_cnt", 32'(q0.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("burst_frame", pop0(), fr(tg[i], px[i]));
    chk("ovf_sticky", 32'(o0), 32'd1);

    // Back-to-back frames: gap between first cs_n rise and second fall
    c0 = 24'hC0FFEE; t0 = 1'b1; v0 = 1'b1;
    @(negedge clk);
    c0 = 24'h0BEEF0; t0 = 1'b0;
    t = 0; stage = 0; tr1 = -1; tf2 = -1;
    while (stage < 3 && t < 600) begin
      @(negedge clk);
      v0 = 1'b0;
      t++;
      if (stage == 0 && cs0 == 1'b0) stage = 1;
      else if (stage == 1 && cs0 == 1'b1) begin stage = 2; tr1 = t; end
      else if (stage == 2 && cs0 == 1'b0) begin stage = 3; tf2 = t; end
    end
    chk("b2b_gap", 32'(tf2 - tr1), 32'd3);
    wait_idle(0, 1000);
    chk("b2b_frame_cnt", 32'(q0.size()), 32'd2);
    chk("b2b_frame0", pop0(), fr(1'b1, 24'hC0FFEE));
    chk("b2b_frame1", pop0(), fr(1'b0, 24'h0BEEF0));

    // Reset during bit 10 with a second pixel still queued
    c0 = 24'h13579B; t0 = 1'b0; v0 = 1'b1;
    @(negedge clk);
    c0 = 24'h2468AC;
    nrise = 0; t = 0;
    while (nrise < NB - 10 && t < 600) begin
      @(negedge clk);
      v0 = 1'b0;
      t++;
      if (sc0 == 1'b1 && ps0 == 1'b0 && cs0 == 1'b0) nrise++;
    end
    chk("reached_bit10", 32'(nrise), 32'(NB - 10));
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 32'(r0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n",     32'(cs0), 32'd1);
    chk("abort_sclk",     32'(sc0), 32'd0);
    chk("abort_data",     32'(sd0), 32'd0);
    chk("abort_busy",     32'(b0),  32'd0);
    chk("abort_overflow", 32'(o0),  32'd0);
    qs = q0.size();
    lowseen = 0;
    repeat (300) begin
      @(negedge clk);
      if (cs0 == 1'b0) lowseen++;
    end
    chk("abort_no_frames", 32'(lowseen),     32'd0);
    chk("abort_no_queue",  32'(q0.size()),   32'(qs));
    chk("abort_busy_late", 32'(b0),          32'd0);

    // CLK_DIV=1: fill the FIFO, then push on the very edge of the next pop
    for (int i = 0; i < 5; i++) begin
      c1 = px[i]; t1 = tg[i]; v1 = 1'b1;
      @(negedge clk);
    end
    v1 = 1'b0;
    repeat (PER1 - 4) @(negedge clk);
    chk("full_at_pop_ready", 32'(r1), 32'd0);
    chk("full_at_pop_ovf",   32'(o1), 32'd0);
    c1 = 24'hBADBAD; t1 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("drop_ovf",        32'(o1), 32'd1);
    chk("drop_count_dec",  32'(r1), 32'd1);
    c1 = 24'h7E57ED; t1 = 1'b0; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("refill_full", 32'(r1), 32'd0);
    wait_idle(1, 1500);
    chk("cd1_frame_cnt", 32'(q1.size()), 32'd6);
    for (int i = 0; i < 5; i++) chk("cd1_frame", pop1(), fr(tg[i], px[i]));
    chk("cd1_last_frame", pop1(), fr(1'b0, 24'h7E57ED));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_spi_out.md
# pixel_spi_out

Downstream stage of the Mandelbrot pixel pipeline. Accepts one 24-bit RGB color per `valid_in` pulse from the pixel-computing stage, buffers it in a small FIFO, and serializes each pixel MSB-first on an outbound SPI-style link (`spi_clk_out`, `spi_data_out`, `spi_cs_n`) toward the display or host. It absorbs bursts from the compute stage and flags pixels it has to drop.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLK_DIV`, 2: `clk` cycles per SPI clock half-period; ≥1.
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `valid_in` input 1: one-cycle pulse; `color_in`/`is_mandelbrot_in` valid.
- `color_in` input 24: RGB pixel, [23:16]=R.
- `is_mandelbrot_in` input 1: in-set flag for this pixel.
- `ready_out` output 1: FIFO not full (combinational from count).
- `spi_clk_out` output 1: serial clock, idle low.
- `spi_data_out` output 1: serial data; receiver samples on `spi_clk_out` rising.
- `spi_cs_n` output 1: frame select, active low.
- `busy` output 1: FSM not in IDLE or FIFO non-empty.
- `overflow` output 1: sticky; a pixel was dropped.

## Operation
- FIFO: push when `valid_in && !full`. `valid_in` while full → pixel dropped, `overflow` set; cleared only by `rst`. A push and a pop in the same cycle are both honoured; a push into a full FIFO is dropped even when a pop occurs in that cycle.
- Frame width N = 24, or 25 with `PIXEL_TAG_EN`.
- FSM states: IDLE → SETUP → SHIFT → HOLD → IDLE.
  - IDLE: `cs_n`=1, `sclk`=0, `data`=0. If FIFO is non-empty: pop the head into the shift register and go to SETUP.
  - SETUP: `cs_n`=0, `data`=bit N-1, `sclk`=0, for CLK_DIV cycles. Then go to SHIFT.
  - SHIFT: each bit drives `sclk`=1 for CLK_DIV cycles, then `sclk`=0 for CLK_DIV cycles. On the high→low transition the shift register advances and `data` presents the next bit. After the low phase of bit 0, go to HOLD.
  - HOLD: `cs_n`=1, `sclk`=0, `data`=0 for CLK_DIV cycles. Then go to IDLE.
- IDLE always lasts at least 1 cycle. This gives a guaranteed inter-frame gap of CLK_DIV+1 cycles with `cs_n` high.
- Counters: divider counter of width clog2(CLK_DIV); bit counter of width clog2(N+1); FIFO pointers of width clog2(DEPTH) that wrap modulo DEPTH; count register of width clog2(DEPTH)+1.
- `rst` mid-frame: the frame is aborted immediately, the FIFO is emptied, and `overflow` is cleared. No partial continuation.

## Timing
- Reset values (registered outputs, the cycle after `rst` is sampled high): `spi_cs_n`=1, `spi_clk_out`=0, `spi_data_out`=0, `busy`=0, `overflow`=0. `ready_out`=0 while `rst`=1, and 1 after reset releases.
- Latency: `valid_in` at edge k with IDLE and empty FIFO → pop at edge k+1 → `spi_cs_n` falls at edge k+2.
- Frame period, edge of pop to the next possible pop: 1 + CLK_DIV + 2·N·CLK_DIV + CLK_DIV cycles. For N=24 and CLK_DIV=2 this is 101 cycles. `cs_n` is low for CLK_DIV·(2N+1) = 98 cycles.
- All outputs are registered except `ready_out`. `spi_clk_out` is glitch-free.

## Configuration
- `PIXEL_TAG_EN` defined: FIFO entries are 25 bits wide and frames carry 25 bits. `is_mandelbrot_in` is sent first as bit 24, followed by `color_in[23:0]`.
- `PIXEL_TAG_EN` undefined: `is_mandelbrot_in` is ignored and not stored; FIFO entries and frames are 24 bits.

## Test plan
- Single pixel 0xA5C3F0, CLK_DIV=2: `cs_n` falls 2 cycles after `valid_in`. Sampling `data` on 24 `sclk` rising edges yields 1010_0101_1100_0011_1111_0000. `cs_n` is low for 98 cycles. `busy` returns to 0 after 101 cycles.
- 6 `valid_in` on consecutive cycles, DEPTH=4, starting from empty: pixels 1–5 are accepted, `ready_out`=0 in the 6th cycle, and the 6th pixel is dropped with `overflow`=1. Exactly 5 frames are sent, in order.
- Back-to-back: 2 queued pixels → the second `cs_n` fall occurs exactly CLK_DIV+1 cycles after the first `cs_n` rise.
- `rst` asserted for 1 cycle during bit 10 with 2 pixels queued: next cycle `cs_n`=1 and `sclk`=0; no further frames; `busy`=0 and `overflow`=0.
- `PIXEL_TAG_EN`, pixel 0x000000 with `is_mandelbrot_in`=1: frame of 25 bits, first bit 1 then 24 zeros. CLK_DIV=1 → frame period 53 cycles.
- CLK_DIV=1, push into a full FIFO on the same edge as a pop: the pushed pixel is dropped, `overflow`=1, and the count decrements by 1.
